// File: rtl/ram_arbiter.sv
// Two-port arbiter onto a single-port synchronous RAM: grant, issue and capture take 3 cycles per access.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 has fixed priority.
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  output logic        gnt0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  output logic        gnt1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [15:0] address,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic        last_q, last_d;
  logic        win;

  // last_q also identifies the requester owning the access in flight.
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  assign win = (req0 & req1) ? ~last_q : req1;
`else
  assign win = ~req0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata_d   = rdata_q;
    address_d = address_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          last_d    = win;
          address_d = win ? addr1  : addr0;
          data_d    = win ? wdata1 : wdata0;
          wren_d    = win ? we1    : we0;
          gnt0_d    = ~win;
          gnt1_d    = win;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rdata_d = q;
        ack0_d  = ~last_q;
        ack1_d  = last_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= 32'd0;
      address_q <= 16'd0;
      data_q    <= 32'd0;
      wren_q    <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata_q   <= rdata_d;
      address_q <= address_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      last_q    <= last_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata   = rdata_q;
  assign address = address_q;
  assign data    = data_q;
  assign wren    = wren_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a synchronous RAM model behind it.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, ack0, gnt1, ack1, wren;
  logic [31:0] rdata, data, q;
  logic [15:0] address;

  logic [31:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  logic wren_prev = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .gnt0(gnt0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .gnt1(gnt1), .ack1(ack1),
    .rdata(rdata), .address(address), .data(data), .wren(wren), .q(q)
  );

  // Synchronous RAM: q reflects the address registered one edge earlier.
  always @(posedge clk) begin
    if (wren === 1'b1) mem[address] <= data;
    q <= mem[address];
  end

  always @(negedge clk) begin
    if (gnt0 === 1'b1 && gnt1 === 1'b1) viol++;
    if (ack0 === 1'b1 && ack1 === 1'b1) viol++;
    if (wren === 1'b1 && wren_prev === 1'b1) viol++;
    wren_prev = wren;
  end

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [4:0]  e_flags;   // {gnt0, gnt1, ack0, ack1, wren}
    logic        chk_a;
    logic [15:0] e_addr;
    logic        chk_d;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [0:18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic rst,
                        input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1);
    reset = rst;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int   ng;
  logic gseq [0:7];
  int   n_ack, n_g1, acks;
  logic exp_g;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;

    vt[0]  = '{1'b1, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b1,16'h0000, 1'b1,32'h0};
    vt[1]  = '{1'b0, 1'b1,1'b1,16'h0010,32'hDEADBEEF, 1'b0,1'b0,16'h0000,32'h0,        5'b10001, 1'b1,16'h0010, 1'b0,32'h0};
    vt[2]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b1,16'h0010, 1'b0,32'h0};
    vt[3]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00100, 1'b0,16'h0000, 1'b0,32'h0};
    vt[4]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b0,16'h0000, 1'b0,32'h0};
    vt[5]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,16'h0010,32'h0,        5'b01000, 1'b1,16'h0010, 1'b0,32'h0};
    vt[6]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b1,16'h0010, 1'b0,32'h0};
    vt[7]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00010, 1'b0,16'h0000, 1'b1,32'hDEADBEEF};
    vt[8]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b0,16'h0000, 1'b0,32'h0};
    vt[9]  = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b1,16'h1234,32'h0BADF00D, 5'b01001, 1'b1,16'h1234, 1'b0,32'h0};
    vt[10] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b1,16'h1234, 1'b0,32'h0};
    vt[11] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00010, 1'b0,16'h0000, 1'b0,32'h0};
    vt[12] = '{1'b0, 1'b1,1'b0,16'h1234,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b10000, 1'b1,16'h1234, 1'b0,32'h0};
    vt[13] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b0,16'h0000, 1'b0,32'h0};
    vt[14] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00100, 1'b0,16'h0000, 1'b1,32'h0BADF00D};
    vt[15] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b1,16'h0002,32'h11111111, 5'b01001, 1'b1,16'h0002, 1'b0,32'h0};
    vt[16] = '{1'b0, 1'b1,1'b0,16'h0010,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b0,16'h0000, 1'b0,32'h0};
    vt[17] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00010, 1'b0,16'h0000, 1'b0,32'h0};
    vt[18] = '{1'b0, 1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        5'b00000, 1'b0,16'h0000, 1'b0,32'h0};

    for (int i = 0; i < 19; i++) begin
      set_in(vt[i].rst, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
             vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
      step();
      check($sformatf("vec%0d flags", i), 32'({gnt0, gnt1, ack0, ack1, wren}), 32'(vt[i].e_flags));
      if (vt[i].chk_a) check($sformatf("vec%0d address", i), 32'(address), 32'(vt[i].e_addr));
      if (vt[i].chk_d) check($sformatf("vec%0d rdata", i), rdata, vt[i].e_rd);
    end

    // Both requesters held for 12 cycles after a fresh reset.
    set_in(1'b1, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    step();
    set_in(1'b0, 1'b1,1'b0,16'h0020,32'h0, 1'b1,1'b0,16'h0030,32'h0);
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if ((gnt0 === 1'b1 || gnt1 === 1'b1) && ng < 8) begin
        gseq[ng] = gnt1;
        ng++;
      end
    end
    set_in(1'b0, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    check("tie grant count", 32'(ng), 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      exp_g = (i % 2) == 1;
`else
      exp_g = 1'b0;
`endif
      check($sformatf("tie grant %0d winner", i), 32'(gseq[i]), 32'(exp_g));
    end

    // req1 raised right after gnt0 is granted at the next IDLE.
    set_in(1'b1, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    step();
    set_in(1'b0, 1'b1,1'b1,16'h0050,32'h00005555, 1'b0,1'b0,16'h0,32'h0);
    step();
    check("pend gnt0", 32'(gnt0), 32'd1);
    set_in(1'b0, 1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,16'h0050,32'h0);
    n_ack = 0;
    n_g1  = 0;
    for (int n = 1; n <= 10 && n_g1 == 0; n++) begin
      step();
      if (ack0 === 1'b1 && n_ack == 0) n_ack = n;
      if (gnt1 === 1'b1) n_g1 = n;
    end
    set_in(1'b0, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    check("pend ack0 delay", 32'(n_ack), 32'd2);
    check("pend gnt1 delay", 32'(n_g1), 32'd3);
    step();
    step();
    check("pend ack1", 32'(ack1), 32'd1);
    check("pend rdata", rdata, 32'h00005555);

    // Reset during ISSUE of a write aborts the access.
    step();
    set_in(1'b0, 1'b1,1'b1,16'h0040,32'h0000CAFE, 1'b0,1'b0,16'h0,32'h0);
    step();
    check("abort gnt0+wren", 32'({gnt0, wren}), 32'd3);
    set_in(1'b1, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    step();
    check("abort outputs after reset", 32'({gnt0, ack0, wren}), 32'd0);
    set_in(1'b0, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (ack0 === 1'b1 || ack1 === 1'b1 || wren === 1'b1) acks++;
    end
    check("abort no ack/wren", 32'(acks), 32'd0);
    set_in(1'b0, 1'b1,1'b0,16'h0001,32'h0, 1'b1,1'b0,16'h0002,32'h0);
    step();
    check("post-reset tie gnt", 32'({gnt0, gnt1}), 32'd2);
    set_in(1'b0, 1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,16'h0,32'h0);
    for (int c = 0; c < 3; c++) step();

    check("protocol violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
